bexkat1_irq_ctrl: RTL and testbench
===================================

// Module: bexkat1_irq_ctrl
// PURPOSE
//  Prioritising interrupt controller in front of the bexkat1 control FSM's
//  exception entry (S_EXC..). Synchronises NUM_IRQ external lines, applies a
//  mask, picks the highest-priority eligible line and handshakes one request
//  at a time with the CPU. Tracks in-service lines for nesting, cleared by EOI
//  at the end of RTI. Config registers sit on a small word-addressed bus.
// PARAMETERS
//  NUM_IRQ   8     interrupt lines, 1..16; line 0 = highest priority
//  VEC_BASE  4'h8  exc_vec_o = VEC_BASE + line index, mod 16
// PORTS
//  clk_i       in   1        clock
//  rst_i       in   1        async reset, active low
//  irq_i       in   NUM_IRQ  raw async interrupt lines, active high
//  int_en_i    in   1        STATUS interrupt-enable bit from the CPU
//  exc_req_o   out  1        interrupt request to the control FSM
//  exc_vec_o   out  4        vector of the request; stable while exc_req_o=1
//  exc_ack_i   in   1        1-cycle pulse: FSM has taken the request (S_EXC)
//  eoi_i       in   1        1-cycle pulse: RTI completed (S_RTI5)
//  cfg_we_i    in   1        register write strobe
//  cfg_addr_i  in   2        0 MASK, 1 PENDING, 2 INSERVICE, 3 EDGE
//  cfg_data_i  in   NUM_IRQ  write data
//  cfg_data_o  out  NUM_IRQ  combinational read data for cfg_addr_i
// BEHAVIOUR
//  Reset: exc_req_o=0, exc_vec_o=0, MASK=0, PENDING=0, INSERVICE=0, EDGE=0,
//   sync flops=0, FSM=IDLE. Reset mid-request drops the request immediately.
//  Sync: irq_i through 2 flops per line. Level line: PENDING[i]=sync[i]&MASK[i].
//  Eligible: p = lowest set index of PENDING; valid if p exists and
//   (INSERVICE==0 or p < lowest set index of INSERVICE).
//  FSM IDLE: eligible & int_en_i -> REQ; latch exc_vec_o=VEC_BASE+p, held p.
//  FSM REQ: exc_req_o=1. exc_ack_i -> IDLE, INSERVICE[held p] set next cycle.
//   int_en_i=0 & !exc_ack_i -> IDLE (request withdrawn, nothing recorded).
//   Vector never changes in REQ even if a higher line becomes pending.
//   exc_ack_i outside REQ ignored.
//  Latency: irq_i rises at edge N -> sync at N+2 -> exc_req_o high after N+3.
//  EOI: clears the lowest set INSERVICE bit; no-op when INSERVICE==0.
//   Same-cycle ack+eoi: EOI clears from the old INSERVICE, then ack bit set.
//  ACK: after ack, IDLE re-evaluates next cycle; minimum 1 idle cycle between
//   requests. A level line still asserted re-requests only once nesting allows.
//  Writes: MASK RW. INSERVICE RO. PENDING writes ignored for level lines.
//   Widths: cfg bits >= NUM_IRQ read 0. Vector add wraps mod 16.
// CONFIGURATION
//  BEXKAT1_IRQ_EDGE_EN defined: EDGE reg (addr 3, RW) marks edge lines.
//   Edge line: sticky PENDING bit set on synced rising edge while MASK=1,
//   cleared by ack of that line or by writing 1 to PENDING (W1C).
//   Same-cycle set and clear: set wins. Clearing EDGE[i] drops its sticky bit.
//  Undefined: all lines level; addr 3 reads 0, writes ignored; no W1C.
// TESTING
//  MASK=0x04, irq_i[2]=1, int_en=1 -> exc_req_o 3 cycles later, vec=0xA;
//   ack -> req low, INSERVICE=0x04.
//  INSERVICE=0x04, irq 5 and 1 raised -> only line 1 requested (vec=0x9);
//   line 5 waits until two EOIs.
//  Request up, int_en_i dropped before ack -> exc_req_o low next cycle,
//   INSERVICE unchanged.
//  Request up for line 3, line 0 goes pending -> vec stays 0xB until ack.
//  Same-cycle ack(line 0)+eoi with INSERVICE=0x02 -> INSERVICE=0x01.
//  EDGE_EN: EDGE=0x01, 1-cycle pulse on irq_i[0] -> PENDING[0] sticky;
//   W1C 0x01 clears it; reset mid-REQ -> all outputs 0.

Source files
------------

// File: rtl/bexkat1_irq_ctrl.sv
// bexkat1_irq_ctrl: prioritising interrupt controller with nesting for the bexkat1 exception entry.
// Define BEXKAT1_IRQ_EDGE_EN to add the EDGE register, sticky edge-triggered lines and W1C PENDING.
module bexkat1_irq_ctrl #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [3:0]  VEC_BASE = 4'h8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               int_en_i,
  output logic               exc_req_o,
  output logic [3:0]         exc_vec_o,
  input  logic               exc_ack_i,
  input  logic               eoi_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [NUM_IRQ-1:0] cfg_data_i,
  output logic [NUM_IRQ-1:0] cfg_data_o
);
  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t             r_state;
  logic               r_req;
  logic [3:0]         r_vec, r_held;
  logic [NUM_IRQ-1:0] r_sync1, r_sync2, r_mask, r_insvc;
  logic [NUM_IRQ-1:0] w_pend, w_edge_rd, w_ack_oh, w_eoi_clr;
  logic [3:0]         w_p, w_q;
  logic               w_ack, w_elig;
  assign w_ack     = (r_state == S_REQ) && exc_ack_i;
  assign w_ack_oh  = w_ack ? (NUM_IRQ'(1) << r_held) : '0;
  assign w_eoi_clr = eoi_i ? (r_insvc & (~r_insvc + NUM_IRQ'(1))) : '0;
`ifdef BEXKAT1_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] r_edge, r_sticky, r_sync3;
  logic [NUM_IRQ-1:0] w_edge_n, w_w1c, w_sticky_n;
  assign w_edge_n   = (cfg_we_i && cfg_addr_i == 2'd3) ? cfg_data_i : r_edge;
  assign w_w1c      = (cfg_we_i && cfg_addr_i == 2'd1) ? cfg_data_i : '0;
  // a new edge beats a same-cycle clear; leaving edge mode drops the sticky bit
  assign w_sticky_n = ((r_sticky & ~w_w1c & ~w_ack_oh) | (r_sync2 & ~r_sync3 & r_mask & r_edge)) & w_edge_n;
  assign w_pend     = (r_sync2 & r_mask & ~r_edge) | (r_sticky & r_edge);
  assign w_edge_rd  = r_edge;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_edge   <= '0;
      r_sticky <= '0;
      r_sync3  <= '0;
    end else begin
      r_edge   <= w_edge_n;
      r_sticky <= w_sticky_n;
      r_sync3  <= r_sync2;
    end
  end
`else
  assign w_pend    = r_sync2 & r_mask;
  assign w_edge_rd = '0;
`endif
  always_comb begin
    w_p = '0;
    w_q = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) w_p = 4'(i);
      if (r_insvc[i]) w_q = 4'(i);
    end
  end
  assign w_elig     = |w_pend && (~|r_insvc || w_p < w_q);
  assign exc_req_o  = r_req;
  assign exc_vec_o  = r_vec;
  assign cfg_data_o = cfg_addr_i == 2'd0 ? r_mask :
                      cfg_addr_i == 2'd1 ? w_pend :
                      cfg_addr_i == 2'd2 ? r_insvc : w_edge_rd;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_vec   <= '0;
      r_held  <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_mask  <= '0;
      r_insvc <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
      if (cfg_we_i && cfg_addr_i == 2'd0) r_mask <= cfg_data_i;
      r_insvc <= (r_insvc & ~w_eoi_clr) | w_ack_oh;
      if (r_state == S_IDLE) begin
        if (w_elig && int_en_i) begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_vec   <= VEC_BASE + w_p;
          r_held  <= w_p;
        end
      end else if (exc_ack_i || !int_en_i) begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bexkat1_irq_ctrl.sv
// tb_bexkat1_irq_ctrl: directed table plus hand-written sequences for bexkat1_irq_ctrl.
module tb_bexkat1_irq_ctrl;
  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic [7:0] irq_i = '0;
  logic       int_en_i = 1'b0, exc_ack_i = 1'b0, eoi_i = 1'b0, cfg_we_i = 1'b0;
  logic [1:0] cfg_addr_i = '0;
  logic [7:0] cfg_data_i = '0;
  logic       exc_req_o;
  logic [3:0] exc_vec_o;
  logic [7:0] cfg_data_o;
  int n_cmp = 0, n_err = 0;
`ifdef BEXKAT1_IRQ_EDGE_EN
  localparam logic [7:0] EDGE_RD = 8'hFF;
`else
  localparam logic [7:0] EDGE_RD = 8'h00;
`endif
  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] irq;
    logic [1:0] raddr;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  bexkat1_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(4'h8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .int_en_i(int_en_i),
    .exc_req_o(exc_req_o), .exc_vec_o(exc_vec_o), .exc_ack_i(exc_ack_i), .eoi_i(eoi_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i), .cfg_data_o(cfg_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, input string name, input logic [7:0] exp);
    cfg_addr_i = a;
    #1;
    chk(name, cfg_data_o, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    tick();
    cfg_we_i = 1'b0;
  endtask
  task automatic ack(input logic with_eoi);
    exc_ack_i = 1'b1; eoi_i = with_eoi;
    tick();
    exc_ack_i = 1'b0; eoi_i = 1'b0;
  endtask
  task automatic eoi();
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd0, 8'hA5, 8'h00, 2'd0, 8'hA5};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 8'hFF, 2'd1, 8'hA5};
    tbl[2] = '{1'b1, 2'd1, 8'hFF, 8'hFF, 2'd1, 8'hA5};
    tbl[3] = '{1'b1, 2'd2, 8'hFF, 8'h00, 2'd2, 8'h00};
    tbl[4] = '{1'b1, 2'd0, 8'h0F, 8'hF0, 2'd1, 8'h00};
    tbl[5] = '{1'b1, 2'd0, 8'hFF, 8'h3C, 2'd1, 8'h3C};
    tbl[6] = '{1'b1, 2'd3, 8'hFF, 8'h00, 2'd3, EDGE_RD};
    tbl[7] = '{1'b1, 2'd3, 8'h00, 8'h00, 2'd3, 8'h00};
    ticks(2);
    chk("rst_req", {7'b0, exc_req_o}, 8'h00);
    chk("rst_vec", {4'b0, exc_vec_o}, 8'h00);
    rd(2'd0, "rst_mask", 8'h00);
    rd(2'd1, "rst_pend", 8'h00);
    rd(2'd2, "rst_insvc", 8'h00);
    rst_i = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      irq_i = tbl[i].irq;
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      else tick();
      ticks(3);
      rd(tbl[i].raddr, $sformatf("tbl%0d", i), tbl[i].exp);
      chk($sformatf("tbl%0d_noreq", i), {7'b0, exc_req_o}, 8'h00);
    end
    irq_i = '0;
    wr(2'd0, 8'h00);
    ticks(3);
    // latency and first acknowledge
    wr(2'd0, 8'h04);
    int_en_i = 1'b1;
    irq_i = 8'h04;
    tick();
    chk("lat_n1", {7'b0, exc_req_o}, 8'h00);
    tick();
    chk("lat_n2", {7'b0, exc_req_o}, 8'h00);
    tick();
    chk("lat_n3", {7'b0, exc_req_o}, 8'h01);
    chk("lat_vec", {4'b0, exc_vec_o}, 8'h0A);
    ack(1'b0);
    chk("ack_req", {7'b0, exc_req_o}, 8'h00);
    rd(2'd2, "ack_insvc", 8'h04);
    ticks(2);
    chk("nest_block", {7'b0, exc_req_o}, 8'h00);
    // nesting: line 1 preempts in-service line 2, line 5 waits
    irq_i = 8'h26;
    wr(2'd0, 8'hFF);
    tick();
    chk("nest_wait", {7'b0, exc_req_o}, 8'h00);
    tick();
    chk("nest_req", {7'b0, exc_req_o}, 8'h01);
    chk("nest_vec", {4'b0, exc_vec_o}, 8'h09);
    ack(1'b0);
    rd(2'd2, "nest_insvc", 8'h06);
    irq_i = 8'h20;
    ticks(3);
    chk("l5_wait0", {7'b0, exc_req_o}, 8'h00);
    eoi();
    rd(2'd2, "eoi1_insvc", 8'h04);
    ticks(2);
    chk("l5_wait1", {7'b0, exc_req_o}, 8'h00);
    eoi();
    chk("l5_gap", {7'b0, exc_req_o}, 8'h00);
    tick();
    chk("l5_req", {7'b0, exc_req_o}, 8'h01);
    chk("l5_vec", {4'b0, exc_vec_o}, 8'h0D);
    ack(1'b0);
    rd(2'd2, "l5_insvc", 8'h20);
    irq_i = '0;
    eoi();
    ticks(2);
    // same-cycle ack of line 0 and EOI
    int_en_i = 1'b0;
    irq_i = 8'h02;
    ticks(3);
    int_en_i = 1'b1;
    tick();
    chk("l1_vec", {4'b0, exc_vec_o}, 8'h09);
    ack(1'b0);
    rd(2'd2, "l1_insvc", 8'h02);
    irq_i = 8'h03;
    ticks(2);
    chk("l0_wait", {7'b0, exc_req_o}, 8'h00);
    tick();
    chk("l0_req", {7'b0, exc_req_o}, 8'h01);
    chk("l0_vec", {4'b0, exc_vec_o}, 8'h08);
    ack(1'b1);
    rd(2'd2, "ackeoi_insvc", 8'h01);
    chk("ackeoi_req", {7'b0, exc_req_o}, 8'h00);
    int_en_i = 1'b0;
    irq_i = '0;
    eoi();
    rd(2'd2, "clean_insvc", 8'h00);
    ticks(2);
    // vector held in REQ, then withdrawal by int_en
    irq_i = 8'h08;
    int_en_i = 1'b1;
    ticks(3);
    chk("l3_req", {7'b0, exc_req_o}, 8'h01);
    chk("l3_vec", {4'b0, exc_vec_o}, 8'h0B);
    irq_i = 8'h09;
    ticks(3);
    chk("hold_req", {7'b0, exc_req_o}, 8'h01);
    chk("hold_vec", {4'b0, exc_vec_o}, 8'h0B);
    int_en_i = 1'b0;
    tick();
    chk("wd_req", {7'b0, exc_req_o}, 8'h00);
    rd(2'd2, "wd_insvc", 8'h00);
    irq_i = '0;
    ticks(3);
`ifdef BEXKAT1_IRQ_EDGE_EN
    wr(2'd0, 8'h01);
    wr(2'd3, 8'h01);
    irq_i = 8'h01;
    tick();
    irq_i = '0;
    ticks(3);
    rd(2'd1, "edge_sticky", 8'h01);
    wr(2'd1, 8'h01);
    rd(2'd1, "edge_w1c", 8'h00);
    int_en_i = 1'b1;
    irq_i = 8'h01;
    tick();
    irq_i = '0;
    ticks(3);
    chk("edge_req", {7'b0, exc_req_o}, 8'h01);
    chk("edge_vec", {4'b0, exc_vec_o}, 8'h08);
    ack(1'b0);
    rd(2'd1, "edge_ackclr", 8'h00);
    rd(2'd2, "edge_insvc", 8'h01);
    int_en_i = 1'b0;
    eoi();
`endif
    // reset while a request is up
    irq_i = 8'h10;
    wr(2'd0, 8'h10);
    int_en_i = 1'b1;
    ticks(2);
    chk("pre_rst_req", {7'b0, exc_req_o}, 8'h01);
    chk("pre_rst_vec", {4'b0, exc_vec_o}, 8'h0C);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_req", {7'b0, exc_req_o}, 8'h00);
    chk("mid_rst_vec", {4'b0, exc_vec_o}, 8'h00);
    rd(2'd0, "mid_rst_mask", 8'h00);
    tick();
    rst_i = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
